// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and constants for the keypad scan controller.
package keypad_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDeb,
    StRow,
    StSamp,
    StPush,
    StRel
  } state_e;

  localparam logic [2:0] ADDR_KEY  = 3'b000;
  localparam logic [2:0] ADDR_STAT = 3'b010;
  localparam logic [2:0] ADDR_CTRL = 3'b100;

  localparam int unsigned CTRL_SCAN_EN = 0;
  localparam int unsigned CTRL_IRQ_EN  = 1;
  localparam int unsigned CTRL_CLEAR   = 2;

  // Hex legend printed on the keypad, indexed by strobed row and low column.
  function automatic logic [3:0] keycode_lut(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] kc;
    case ({r, c})
      4'b00_00: kc = 4'h1;
      4'b00_01: kc = 4'h4;
      4'b00_10: kc = 4'h7;
      4'b00_11: kc = 4'hE;
      4'b01_00: kc = 4'h2;
      4'b01_01: kc = 4'h5;
      4'b01_10: kc = 4'h8;
      4'b01_11: kc = 4'h0;
      4'b10_00: kc = 4'h3;
      4'b10_01: kc = 4'h6;
      4'b10_10: kc = 4'h9;
      4'b10_11: kc = 4'hF;
      4'b11_00: kc = 4'hA;
      4'b11_01: kc = 4'hB;
      4'b11_10: kc = 4'hC;
      default:  kc = 4'hD;
    endcase
    return kc;
  endfunction

  // Index of the lowest active-low column; only meaningful when some column is low.
  function automatic logic [1:0] first_low(input logic [3:0] col);
    if (!col[0])      return 2'd0;
    else if (!col[1]) return 2'd1;
    else if (!col[2]) return 2'd2;
    else              return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// I/O bus window of the keypad controller plus its interrupt line.
interface keypad_scan_ctrl_if;
  logic        read_enable;
  logic        write_enable;
  logic [2:0]  address;
  logic [15:0] write_data;
  logic [15:0] read_data_output;
  logic        interrupt;

  modport master (
    output read_enable, write_enable, address, write_data,
    input  read_data_output, interrupt
  );

  modport slave (
    input  read_enable, write_enable, address, write_data,
    output read_data_output, interrupt
  );
endinterface

// File: rtl/keypad_scan_ctrl_fifo.sv
// Keycode queue with sticky overflow; clear beats push, push+pop always legal.
module key_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             ovf;
  logic             do_push, do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign count    = cnt;
  assign overflow = ovf;
  assign head     = mem[rd_ptr];

  // A pop frees the slot this cycle, so a push into a full queue still fits.
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & ~clear & (~full | do_pop);

  // Pointer, occupancy and overflow bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push && !do_push) ovf <= 1'b1;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad sequencer: debounce, row scan, keycode queue and bus registers.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        column,
  output logic [3:0]        row,
  keypad_scan_ctrl_if.slave bus
);
  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [1:0]                  r_q, r_d;
  logic [3:0]                  code_q, code_d;
  logic                        scan_en_q, irq_en_q;
  logic                        key_low, fifo_push, fifo_pop, fifo_clear, wr_ctrl;
  logic [3:0]                  fifo_head;
  logic                        fifo_full, fifo_empty, fifo_ovf;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [15:0]                 count_ext;
  logic [CNT_W-1:0]            cnt_inc;

  assign key_low = (column != 4'b1111);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // FSM, debounce counter and scan-row state registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      r_q     <= 2'd0;
      code_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      code_q  <= code_d;
    end
  end

  // Next-state: debounce press, walk rows, push once, debounce release.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    code_d    = code_q;
    fifo_push = 1'b0;
    if (!scan_en_q && state_q != StIdle) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (scan_en_q && key_low) state_d = StDeb;
        end
        StDeb: begin
          if (!key_low) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = StRow;
            cnt_d   = '0;
            r_d     = 2'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StRow: state_d = StSamp;
        StSamp: begin
          if (key_low) begin
            code_d  = keycode_lut(r_q, first_low(column));
            state_d = StPush;
          end else if (r_q == 2'd3) begin
            state_d = StIdle;
          end else begin
            r_d     = r_q + 2'd1;
            state_d = StRow;
          end
        end
        StPush: begin
          fifo_push = 1'b1;
          cnt_d     = '0;
          state_d   = StRel;
        end
        StRel: begin
          if (key_low) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Row strobe is held from the settle cycle until the push completes.
  always_comb begin
    row = 4'b0000;
    if (state_q == StRow || state_q == StSamp || state_q == StPush) row = ~(4'b0001 << r_q);
  end

  assign wr_ctrl    = bus.write_enable && (bus.address == ADDR_CTRL);
  assign fifo_clear = wr_ctrl && bus.write_data[CTRL_CLEAR];
  assign fifo_pop   = bus.read_enable && (bus.address == ADDR_KEY);

  // CTRL enables; the clear bit is a strobe and is never stored.
  always_ff @(posedge clock) begin
    if (!reset) begin
      scan_en_q <= 1'b1;
      irq_en_q  <= 1'b1;
    end else if (wr_ctrl) begin
      scan_en_q <= bus.write_data[CTRL_SCAN_EN];
      irq_en_q  <= bus.write_data[CTRL_IRQ_EN];
    end
  end

  key_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (code_q),
    .pop       (fifo_pop),
    .clear     (fifo_clear),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_ovf)
  );

  assign count_ext = 16'(fifo_count);

  // Combinational read mux; idle bus reads as zero.
  always_comb begin
    bus.read_data_output = 16'h0000;
    if (bus.read_enable) begin
      case (bus.address)
        ADDR_KEY:  if (!fifo_empty) bus.read_data_output = {12'b0, fifo_head};
        ADDR_STAT: bus.read_data_output = {11'b0, count_ext[2:0], fifo_ovf, ~fifo_empty};
        ADDR_CTRL: bus.read_data_output = {14'b0, irq_en_q, scan_en_q};
        default:   bus.read_data_output = 16'h0000;
      endcase
    end
  end

  assign bus.interrupt = irq_en_q & ~fifo_empty;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model, queue-based reference model,
// keycode table sweep, directed corner cases and random press/read traffic.
module tb_keypad_scan_ctrl;
  localparam int unsigned DEB   = 8;
  localparam int unsigned DEPTH = 4;
  localparam logic [2:0]  A_KEY  = 3'b000;
  localparam logic [2:0]  A_STAT = 3'b010;
  localparam logic [2:0]  A_CTRL = 3'b100;

  typedef struct {
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
  } key_vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] column, row;
  logic       key_down = 1'b0;
  logic [1:0] key_r = 2'd0, key_c = 2'd0;

  int vectors = 0;
  int miscompares = 0;

  key_vec_t   tbl [16];
  logic [3:0] mq [$];
  bit         m_ovf = 1'b0;
  bit         m_irq_en = 1'b1;

  keypad_scan_ctrl_if bus ();

  keypad_scan_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .column (column),
    .row    (row),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // A held key shorts its column low whenever its row is driven low.
  always_comb begin
    column = 4'b1111;
    if (key_down && !row[key_r]) column[key_c] = 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] m_stat();
    return {11'b0, 3'(mq.size()), m_ovf, (mq.size() != 0)};
  endfunction

  function automatic logic [15:0] m_irq();
    return 16'(m_irq_en && (mq.size() != 0));
  endfunction

  function automatic void m_push(input logic [3:0] code);
    if (mq.size() == DEPTH) m_ovf = 1'b1;
    else mq.push_back(code);
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_irq_en = 1'b1;
  endfunction

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clock);
    bus.read_enable = 1'b1;
    bus.address = a;
    #1 d = bus.read_data_output;
    @(posedge clock);
    #1 bus.read_enable = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clock);
    bus.write_enable = 1'b1;
    bus.address = a;
    bus.write_data = d;
    @(posedge clock);
    #1 bus.write_enable = 1'b0;
    if (a == A_CTRL) begin
      m_irq_en = d[1];
      if (d[2]) begin
        mq.delete();
        m_ovf = 1'b0;
      end
    end
  endtask

  task automatic read_key_check(input string name);
    logic [15:0] d, exp;
    exp = (mq.size() != 0) ? {12'b0, mq[0]} : 16'h0000;
    bus_read(A_KEY, d);
    if (mq.size() != 0) void'(mq.pop_front());
    check(name, d, exp);
  endtask

  task automatic read_stat_check(input string name);
    logic [15:0] d;
    bus_read(A_STAT, d);
    check(name, d, m_stat());
  endtask

  // Full press/release of one key; optionally reads KEY in the push cycle.
  task automatic press(input logic [1:0] kr, input logic [1:0] kc, input int hold,
                       input bit pop_at_push);
    logic [15:0] d, exp;
    logic [3:0]  strobe;
    strobe = ~(4'b0001 << kr);
    @(negedge clock);
    key_r = kr;
    key_c = kc;
    key_down = 1'b1;
    for (int n = 0; n < 4 * DEB + 64; n++) begin
      @(negedge clock);
      if (row == strobe) break;
    end
    check("row_strobe", 16'(row), 16'(strobe));
    @(negedge clock);  // settle done, sampling
    @(negedge clock);  // push cycle
    check("irq_before_push", 16'(bus.interrupt), m_irq());
    if (pop_at_push) begin
      bus.read_enable = 1'b1;
      bus.address = A_KEY;
      #1 d = bus.read_data_output;
      exp = (mq.size() != 0) ? {12'b0, mq[0]} : 16'h0000;
      if (mq.size() != 0) void'(mq.pop_front());
      check("key_at_push", d, exp);
      @(posedge clock);
      #1 bus.read_enable = 1'b0;
    end
    m_push(tbl[{kr, kc}].code);
    @(negedge clock);
    check("irq_after_push", 16'(bus.interrupt), m_irq());
    check("row_release", 16'(row), 16'h0000);
    repeat (hold) @(negedge clock);
    key_down = 1'b0;
    repeat (DEB + 4) @(negedge clock);
  endtask

  initial begin
    logic [15:0] d;
    bit          row_seen;

    tbl[0]  = '{2'd0, 2'd0, 4'h1};  tbl[1]  = '{2'd0, 2'd1, 4'h4};
    tbl[2]  = '{2'd0, 2'd2, 4'h7};  tbl[3]  = '{2'd0, 2'd3, 4'hE};
    tbl[4]  = '{2'd1, 2'd0, 4'h2};  tbl[5]  = '{2'd1, 2'd1, 4'h5};
    tbl[6]  = '{2'd1, 2'd2, 4'h8};  tbl[7]  = '{2'd1, 2'd3, 4'h0};
    tbl[8]  = '{2'd2, 2'd0, 4'h3};  tbl[9]  = '{2'd2, 2'd1, 4'h6};
    tbl[10] = '{2'd2, 2'd2, 4'h9};  tbl[11] = '{2'd2, 2'd3, 4'hF};
    tbl[12] = '{2'd3, 2'd0, 4'hA};  tbl[13] = '{2'd3, 2'd1, 4'hB};
    tbl[14] = '{2'd3, 2'd2, 4'hC};  tbl[15] = '{2'd3, 2'd3, 4'hD};

    bus.read_enable = 1'b0;
    bus.write_enable = 1'b0;
    bus.address = 3'b000;
    bus.write_data = 16'h0000;

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_row", 16'(row), 16'h0000);
    check("reset_irq", 16'(bus.interrupt), 16'h0000);
    check("reset_rdata_idle", bus.read_data_output, 16'h0000);
    reset = 1'b1;
    read_stat_check("reset_stat");
    bus_read(A_CTRL, d);
    check("reset_ctrl", d, 16'h0003);
    bus_write(3'b110, 16'h0000);
    bus_read(3'b110, d);
    check("unmapped_read", d, 16'h0000);
    bus_read(A_CTRL, d);
    check("unmapped_write_ignored", d, 16'h0003);

    // Keycode map sweep
    for (int i = 0; i < 16; i++) begin
      press(tbl[i].r, tbl[i].c, DEB, 1'b0);
      bus_read(A_KEY, d);
      void'(mq.pop_front());
      check($sformatf("keymap_r%0d_c%0d", tbl[i].r, tbl[i].c), d, {12'b0, tbl[i].code});
    end

    // Single long press r1/c2, interrupt drops after the read
    press(2'd1, 2'd2, 3 * DEB, 1'b0);
    check("t1_irq_pending", 16'(bus.interrupt), 16'h0001);
    read_key_check("t1_key");
    check("t1_irq_cleared", 16'(bus.interrupt), 16'h0000);
    read_stat_check("t1_stat");

    // Bounce shorter than the debounce window
    row_seen = 1'b0;
    @(negedge clock);
    key_r = 2'd1;
    key_c = 2'd1;
    key_down = 1'b1;
    repeat (DEB / 2) begin
      @(negedge clock);
      if (row != 4'b0000) row_seen = 1'b1;
    end
    key_down = 1'b0;
    repeat (2 * DEB) begin
      @(negedge clock);
      if (row != 4'b0000) row_seen = 1'b1;
    end
    check("t2_no_scan", 16'(row_seen), 16'h0000);
    check("t2_irq", 16'(bus.interrupt), 16'h0000);
    read_stat_check("t2_stat");

    // Five presses without reads: fifth is dropped, overflow sticks
    press(2'd0, 2'd0, 2, 1'b0);
    press(2'd0, 2'd1, 2, 1'b0);
    press(2'd1, 2'd0, 2, 1'b0);
    press(2'd2, 2'd3, 2, 1'b0);
    press(2'd3, 2'd3, 2, 1'b0);
    read_stat_check("t3_stat_full_ovf");
    for (int i = 0; i < 5; i++) read_key_check($sformatf("t3_key%0d", i));
    read_stat_check("t3_stat_drained");

    // Clear with three queued
    press(2'd3, 2'd0, 2, 1'b0);
    press(2'd2, 2'd1, 2, 1'b0);
    press(2'd0, 2'd3, 2, 1'b0);
    bus_write(A_CTRL, 16'h0007);
    read_stat_check("t5_stat_cleared");
    check("t5_irq", 16'(bus.interrupt), 16'h0000);
    bus_read(A_CTRL, d);
    check("t5_ctrl", d, 16'h0003);

    // Pop coinciding with push into a full queue
    press(2'd0, 2'd2, 2, 1'b0);
    press(2'd1, 2'd3, 2, 1'b0);
    press(2'd2, 2'd2, 2, 1'b0);
    press(2'd3, 2'd1, 2, 1'b0);
    press(2'd1, 2'd1, 2, 1'b1);
    read_stat_check("t4_stat");
    for (int i = 0; i < 4; i++) read_key_check($sformatf("t4_key%0d", i));

    // Interrupt masking and scan disable during debounce
    press(2'd2, 2'd0, 2, 1'b0);
    bus_write(A_CTRL, 16'h0001);
    check("irq_masked", 16'(bus.interrupt), 16'h0000);
    bus_write(A_CTRL, 16'h0003);
    check("irq_unmasked", 16'(bus.interrupt), 16'h0001);
    read_key_check("mask_key");
    @(negedge clock);
    key_r = 2'd0;
    key_c = 2'd0;
    key_down = 1'b1;
    repeat (DEB / 2) @(negedge clock);
    bus_write(A_CTRL, 16'h0002);
    row_seen = 1'b0;
    repeat (3 * DEB) begin
      @(negedge clock);
      if (row != 4'b0000) row_seen = 1'b1;
    end
    key_down = 1'b0;
    check("scan_off_no_scan", 16'(row_seen), 16'h0000);
    read_stat_check("scan_off_stat");
    bus_write(A_CTRL, 16'h0003);

    // Reset asserted while sampling row 2
    press(2'd0, 2'd1, 2, 1'b0);
    @(negedge clock);
    key_r = 2'd2;
    key_c = 2'd1;
    key_down = 1'b1;
    for (int n = 0; n < 4 * DEB + 64; n++) begin
      @(negedge clock);
      if (row == 4'b1011) break;
    end
    @(negedge clock);
    check("t6_row_in_samp", 16'(row), 16'h000b);
    reset = 1'b0;
    @(negedge clock);
    key_down = 1'b0;
    m_reset();
    check("t6_row_after_reset", 16'(row), 16'h0000);
    check("t6_irq_after_reset", 16'(bus.interrupt), 16'h0000);
    reset = 1'b1;
    repeat (DEB + 4) @(negedge clock);
    read_stat_check("t6_stat");

    // Random presses and reads against the model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 1: press(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    int'($urandom_range(1, DEB)), ($urandom_range(0, 3) == 0));
        2:    read_key_check("rand_key");
        default: read_stat_check("rand_stat");
      endcase
    end
    while (mq.size() != 0) read_key_check("rand_drain");
    read_stat_check("rand_final_stat");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
